vector_exec_unit: RTL

- Execute stage directly downstream of the vector decoder; consumes its registered outputs (sel, operation, vci, rd/vd, imm, imm_5, scalar and vector operands).
- Vector arithmetic is lane-serial: LANES elements per cycle over VL/LANES beats. stall_o back-pressures the decoder while a vector op is in flight.
- ADDI and unit-stride load/store address generation complete in one cycle. All results are registered toward the writeback/memory stage.

---
 rtl/vector_exec_unit.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vector_exec_unit.sv
// vector_exec_unit
//   Execute stage that sits directly after the vector decoder. Vector
//   arithmetic (ADD, SUB, MULADD, SLIDE1UP, SLIDE1DOWN) is lane-serial:
//   LANES elements are produced per cycle over N = VL/LANES beats, and the
//   decoder is held with stall_o while an op is in flight. ADDI and
//   unit-stride load/store address generation finish in one cycle. Every
//   result is registered toward the writeback/memory stage.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   sel_i             0=ADDI 1=VLE32 2=VSE32 3=ARITH, others ignored
//   operation_i       0=SUB 1=ADD 2=SLIDE1UP 3=SLIDE1DOWN 5=MULADD
//   vci_i             0=VV 1=VX 2=VI 3=invalid (slides ignore it)
//   rd_i, vd_i        scalar / vector destination indices
//   imm_i, imm_5_i    I-type immediate, vector immediate
//   rs1_i, rs2_i      scalar operands
//   vs1_i..vs3_i      vector operands (vs3 = old vd), element i at [i*SEW +: SEW]
//   stall_o, busy_o   hold request to decoder, state != IDLE
//   vwe_o, vd_o, vres_o           vector writeback (vwe_o is a one-cycle pulse)
//   xwe_o, rd_o, xres_o           scalar writeback (xwe_o is a one-cycle pulse)
//   mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o   memory request

module vector_exec_unit #(
  parameter int VL    = 8,
  parameter int SEW   = 32,
  parameter int LANES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          sel_i,
  input  logic [3:0]          operation_i,
  input  logic [1:0]          vci_i,
  input  logic [4:0]          rd_i,
  input  logic [4:0]          vd_i,
  input  logic [11:0]         imm_i,
  input  logic [4:0]          imm_5_i,
  input  logic [31:0]         rs1_i,
  input  logic [31:0]         rs2_i,
  input  logic [VL*SEW-1:0]   vs1_i,
  input  logic [VL*SEW-1:0]   vs2_i,
  input  logic [VL*SEW-1:0]   vs3_i,
  output logic                stall_o,
  output logic                busy_o,
  output logic                vwe_o,
  output logic [4:0]          vd_o,
  output logic [VL*SEW-1:0]   vres_o,
  output logic                xwe_o,
  output logic [4:0]          rd_o,
  output logic [31:0]         xres_o,
  output logic                mem_valid_o,
  output logic                mem_we_o,
  output logic [31:0]         mem_addr_o,
  output logic [VL*SEW-1:0]   mem_wdata_o
);

  localparam int N  = VL / LANES;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (VL > 1) ? $clog2(VL) : 1;
  localparam int VW = VL * SEW;

  localparam logic [3:0] SEL_ADDI  = 4'd0;
  localparam logic [3:0] SEL_VLE   = 4'd1;
  localparam logic [3:0] SEL_VSE   = 4'd2;
  localparam logic [3:0] SEL_ARITH = 4'd3;

  localparam logic [3:0] OP_SUB    = 4'd0;
  localparam logic [3:0] OP_ADD    = 4'd1;
  localparam logic [3:0] OP_SLUP   = 4'd2;
  localparam logic [3:0] OP_SLDOWN = 4'd3;
  localparam logic [3:0] OP_MULADD = 4'd5;

  localparam logic [1:0] VCI_VV  = 2'd0;
  localparam logic [1:0] VCI_VX  = 2'd1;
  localparam logic [1:0] VCI_VI  = 2'd2;
  localparam logic [1:0] VCI_BAD = 2'd3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg;
  logic [BW-1:0]   beat_reg;

  // Operand copies taken at accept; the decoder may move on before the op ends.
  logic [3:0]      op_reg;
  logic [1:0]      vci_reg;
  logic [4:0]      vd_reg;
  logic [4:0]      imm5_reg;
  logic [31:0]     rs1_reg;
  logic [VW-1:0]   vs1_reg;
  logic [VW-1:0]   vs2_reg;
  logic [VW-1:0]   vs3_reg;

  logic [VW-1:0]         res_reg;
  logic [VW-1:0]         res_next;
  logic [LANES*SEW-1:0]  lane_flat;

  logic op_valid;
  logic accept;
  logic last_beat;

  // rs2 is part of the decoder interface but no supported op reads it.
  logic unused_rs2;
  assign unused_rs2 = ^rs2_i;

  always_comb begin
    op_valid = 1'b0;
    case (operation_i)
      OP_SUB, OP_ADD, OP_MULADD: op_valid = (vci_i != VCI_BAD);
      OP_SLUP, OP_SLDOWN:        op_valid = 1'b1;
      default:                   op_valid = 1'b0;
    endcase
  end

  assign accept    = (state_reg == IDLE) && (sel_i == SEL_ARITH) && op_valid;
  assign last_beat = (beat_reg == BW'(N - 1));

  // The final beat drops the stall so the decoder advances on the same edge
  // that moves this unit to DONE.
  assign stall_o = rst && (accept || ((state_reg == BUSY) && !last_beat));
  assign busy_o  = rst && (state_reg != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [IW-1:0]  elem_idx;
      logic [IW-1:0]  prev_idx;
      logic [IW-1:0]  next_idx;
      logic [SEW-1:0] elem_a;
      logic [SEW-1:0] elem_b;
      logic [SEW-1:0] elem_c;
      logic [SEW-1:0] lane_val;

      always_comb begin
        elem_idx = IW'(beat_reg) * IW'(LANES) + IW'(gi);
        // Clamp neighbour indices so the part-selects never leave the vector;
        // the edge elements take rs1 instead.
        prev_idx = (elem_idx == '0) ? elem_idx : elem_idx - 1'b1;
        next_idx = (elem_idx == IW'(VL - 1)) ? elem_idx : elem_idx + 1'b1;
        elem_a   = vs2_reg[elem_idx*SEW +: SEW];
        elem_c   = vs3_reg[elem_idx*SEW +: SEW];
        case (vci_reg)
          VCI_VX:  elem_b = SEW'(rs1_reg);
          VCI_VI:  elem_b = {{(SEW-5){imm5_reg[4]}}, imm5_reg};
          VCI_VV:  elem_b = vs1_reg[elem_idx*SEW +: SEW];
          default: elem_b = vs1_reg[elem_idx*SEW +: SEW];
        endcase
        case (op_reg)
          OP_ADD:    lane_val = elem_a + elem_b;
          OP_SUB:    lane_val = elem_a - elem_b;
          OP_MULADD: lane_val = elem_b * elem_a + elem_c;
          OP_SLUP:   lane_val = (elem_idx == '0) ? SEW'(rs1_reg)
                                                 : vs2_reg[prev_idx*SEW +: SEW];
          OP_SLDOWN: lane_val = (elem_idx == IW'(VL - 1)) ? SEW'(rs1_reg)
                                                          : vs2_reg[next_idx*SEW +: SEW];
          default:   lane_val = elem_a;
        endcase
      end

      assign lane_flat[gi*SEW +: SEW] = lane_val;
    end
  endgenerate

  always_comb begin
    res_next = res_reg;
    for (int l = 0; l < LANES; l++) begin
      res_next[(int'(beat_reg)*LANES + l)*SEW +: SEW] = lane_flat[l*SEW +: SEW];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      beat_reg    <= '0;
      vwe_o       <= 1'b0;
      vd_o        <= '0;
      vres_o      <= '0;
      xwe_o       <= 1'b0;
      rd_o        <= '0;
      xres_o      <= '0;
      mem_valid_o <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      vwe_o       <= 1'b0;
      xwe_o       <= 1'b0;
      mem_valid_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= BUSY;
            beat_reg  <= '0;
          end else begin
            case (sel_i)
              SEL_ADDI: begin
                xwe_o  <= 1'b1;
                rd_o   <= rd_i;
                xres_o <= rs1_i + {{20{imm_i[11]}}, imm_i};
              end
              SEL_VLE: begin
                mem_valid_o <= 1'b1;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= rs1_i;
                vd_o        <= vd_i;
              end
              SEL_VSE: begin
                mem_valid_o <= 1'b1;
                mem_we_o    <= 1'b1;
                mem_addr_o  <= rs1_i;
                mem_wdata_o <= vs3_i;
              end
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (last_beat) begin
            // vwe_o is high for the whole DONE cycle.
            state_reg <= DONE;
            vwe_o     <= 1'b1;
            vres_o    <= res_next;
            vd_o      <= vd_reg;
          end else begin
            beat_reg <= beat_reg + 1'b1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Datapath registers; no reset needed since every op rewrites them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_reg   <= operation_i;
      vci_reg  <= vci_i;
      vd_reg   <= vd_i;
      imm5_reg <= imm_5_i;
      rs1_reg  <= rs1_i;
      vs1_reg  <= vs1_i;
      vs2_reg  <= vs2_i;
      vs3_reg  <= vs3_i;
    end
    if (state_reg == BUSY) begin
      res_reg <= res_next;
    end
  end

endmodule
